// File: rtl/bus_cmd_ctrl_if.sv
// Bus status in, ALE/transceiver/command strobes out, between the CPU core and the system bus.
interface bus_cmd_ctrl_if;
   logic [2:0] s_n;
   logic       ready;
   logic       aen_n;
   logic       ale;
   logic       den;
   logic       dtr;
   logic       mrdc_n;
   logic       mwtc_n;
   logic       amwc_n;
   logic       iorc_n;
   logic       iowc_n;
   logic       aiowc_n;
   logic       inta_n;
   logic       busy;

   // CPU side: drives status, ready and address enable.
   modport master (
      output s_n, ready, aen_n,
      input  ale, den, dtr, mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n, busy
   );

   // Controller side.
   modport slave (
      input  s_n, ready, aen_n,
      output ale, den, dtr, mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n, busy
   );
endinterface

// File: rtl/bus_cmd_ctrl.sv
// 8288-style max-mode bus command controller: decodes CPU status into ALE, transceiver
// controls and command strobes, with forced wait states and external ready.
module bus_cmd_ctrl #(
   parameter int unsigned MEM_WAITS = 0,
   parameter int unsigned IO_WAITS  = 1
) (
   input logic           clk,
   input logic           rst,
   bus_cmd_ctrl_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StTw, StT4} state_e;

   localparam logic [2:0] LpMemWaits = 3'(MEM_WAITS);
   localparam logic [2:0] LpIoWaits  = 3'(IO_WAITS);
   localparam logic [2:0] LpPassive  = 3'b111;
   localparam logic [2:0] LpHalt     = 3'b011;

   state_e     r_state, w_state_d;
   logic [2:0] r_s_q;
   logic [2:0] r_type, w_type_d;
   logic [2:0] r_wcnt, w_wcnt_d;
   logic       w_start;

   logic r_ale, r_den, r_dtr;
   logic r_mrdc_n, r_mwtc_n, r_amwc_n, r_iorc_n, r_iowc_n, r_aiowc_n, r_inta_n;
   logic w_ale_d, w_den_d, w_dtr_d;
   logic w_mrdc_n_d, w_mwtc_n_d, w_amwc_n_d, w_iorc_n_d, w_iowc_n_d, w_aiowc_n_d, w_inta_n_d;

   // Only a passive->active edge of the registered status starts a cycle.
   assign w_start = (r_s_q == LpPassive) && (bus.s_n != LpPassive);

   // Next-state: bus phase sequencing, wait counter and cycle-type latch.
   always_comb begin
      w_state_d = r_state;
      w_type_d  = r_type;
      w_wcnt_d  = r_wcnt;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_d = StT1;
               w_type_d  = bus.s_n;
            end
         end
         StT1: begin
            if (r_type == LpHalt) begin
               w_state_d = StIdle;
            end else begin
               w_state_d = StT2;
               w_wcnt_d  = r_type[2] ? LpMemWaits : LpIoWaits;
            end
         end
         StT2: w_state_d = StT3;
         StT3, StTw: begin
            // Forced waits are consumed before ready is looked at.
            if (r_wcnt != 3'd0) begin
               w_wcnt_d  = r_wcnt - 3'd1;
               w_state_d = StTw;
            end else if (!bus.ready) begin
               w_state_d = StTw;
            end else begin
               w_state_d = StT4;
            end
         end
         StT4:    w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      logic w_cmd, w_late, w_act, w_rd;
      w_cmd  = (w_state_d == StT2) || (w_state_d == StT3) || (w_state_d == StTw);
      w_late = (w_state_d == StT3) || (w_state_d == StTw);
      w_act  = (w_state_d != StIdle);
      w_rd   = (w_type_d == 3'b000) || (w_type_d == 3'b001) ||
               (w_type_d == 3'b100) || (w_type_d == 3'b101);
      w_ale_d     = (w_state_d == StT1);
      w_den_d     = w_cmd;
      w_dtr_d     = !(w_act && w_rd);
      w_mrdc_n_d  = !(w_cmd && (w_type_d == 3'b100 || w_type_d == 3'b101));
      w_amwc_n_d  = !(w_cmd && (w_type_d == 3'b110));
      w_mwtc_n_d  = !(w_late && (w_type_d == 3'b110));
      w_iorc_n_d  = !(w_cmd && (w_type_d == 3'b001));
      w_aiowc_n_d = !(w_cmd && (w_type_d == 3'b010));
      w_iowc_n_d  = !(w_late && (w_type_d == 3'b010));
      w_inta_n_d  = !(w_cmd && (w_type_d == 3'b000));
   end

   // State, status sample and registered outputs; reset aborts any cycle in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_s_q     <= LpPassive;
         r_type    <= LpPassive;
         r_wcnt    <= 3'd0;
         r_ale     <= 1'b0;
         r_den     <= 1'b0;
         r_dtr     <= 1'b1;
         r_mrdc_n  <= 1'b1;
         r_mwtc_n  <= 1'b1;
         r_amwc_n  <= 1'b1;
         r_iorc_n  <= 1'b1;
         r_iowc_n  <= 1'b1;
         r_aiowc_n <= 1'b1;
         r_inta_n  <= 1'b1;
      end else begin
         r_state   <= w_state_d;
         r_s_q     <= bus.s_n;
         r_type    <= w_type_d;
         r_wcnt    <= w_wcnt_d;
         r_ale     <= w_ale_d;
         r_den     <= w_den_d;
         r_dtr     <= w_dtr_d;
         r_mrdc_n  <= w_mrdc_n_d;
         r_mwtc_n  <= w_mwtc_n_d;
         r_amwc_n  <= w_amwc_n_d;
         r_iorc_n  <= w_iorc_n_d;
         r_iowc_n  <= w_iowc_n_d;
         r_aiowc_n <= w_aiowc_n_d;
         r_inta_n  <= w_inta_n_d;
      end
   end

   // While DMA owns the bus, commands are gated off after the flops; sequencing runs on.
   assign bus.ale     = r_ale;
   assign bus.den     = r_den;
   assign bus.dtr     = r_dtr;
   assign bus.mrdc_n  = r_mrdc_n  | bus.aen_n;
   assign bus.mwtc_n  = r_mwtc_n  | bus.aen_n;
   assign bus.amwc_n  = r_amwc_n  | bus.aen_n;
   assign bus.iorc_n  = r_iorc_n  | bus.aen_n;
   assign bus.iowc_n  = r_iowc_n  | bus.aen_n;
   assign bus.aiowc_n = r_aiowc_n | bus.aen_n;
   assign bus.inta_n  = r_inta_n  | bus.aen_n;
   assign bus.busy    = (r_state != StIdle);

endmodule

// File: tb/tb_bus_cmd_ctrl.sv
// Scoreboard bench for bus_cmd_ctrl: each bus cycle pushes its expected profile, a
// negedge monitor measures the profile the DUT produced and compares when busy drops.
module tb_bus_cmd_ctrl;
   localparam int MemWaits = 0;
   localparam int IoWaits  = 1;

   typedef struct {
      string tag;
      int busy, ale, den, dtr_lo;
      int mrdc, mwtc, amwc, iorc, iowc, aiowc, inta;
      int fst, fnw;
   } prof_t;

   logic clk;
   logic rst;
   bus_cmd_ctrl_if bus ();

   bus_cmd_ctrl #(.MEM_WAITS(MemWaits), .IO_WAITS(IoWaits)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int n_push = 0;
   bit mon_en = 1'b0;
   prof_t sb_q[$];

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Expected profile of one bus cycle, from the phase timing T1,T2,T3,TW*,T4.
   function automatic prof_t model(input string tag, input logic [2:0] code, input int r,
                                   input bit aen);
      prof_t e;
      int w, len;
      e = '{tag: tag, busy: 0, ale: 0, den: 0, dtr_lo: 0, mrdc: 0, mwtc: 0, amwc: 0,
            iorc: 0, iowc: 0, aiowc: 0, inta: 0, fst: -1, fnw: -1};
      e.ale = 1;
      if (code == 3'b011) begin
         e.busy = 1;
         return e;
      end
      w = code[2] ? MemWaits : IoWaits;
      len = 4 + w + r;
      e.busy = len;
      e.den = len - 2;
      if (code inside {3'b000, 3'b001, 3'b100, 3'b101}) e.dtr_lo = len;
      if (!aen) begin
         e.fst = 1;
         case (code)
            3'b100, 3'b101: e.mrdc = len - 2;
            3'b001:         e.iorc = len - 2;
            3'b000:         e.inta = len - 2;
            3'b110: begin e.amwc = len - 2; e.mwtc = len - 3; e.fnw = 2; end
            3'b010: begin e.aiowc = len - 2; e.iowc = len - 3; e.fnw = 2; end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Monitor accumulators
   int a_busy = 0, a_ale = 0, a_den = 0, a_dtr = 0, a_mrdc = 0, a_mwtc = 0, a_amwc = 0;
   int a_iorc = 0, a_iowc = 0, a_aiowc = 0, a_inta = 0, a_fst = -1, a_fnw = -1;
   bit prev_busy = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         a_ale   += int'(bus.ale);
         a_den   += int'(bus.den);
         a_dtr   += int'(!bus.dtr);
         a_mrdc  += int'(!bus.mrdc_n);
         a_mwtc  += int'(!bus.mwtc_n);
         a_amwc  += int'(!bus.amwc_n);
         a_iorc  += int'(!bus.iorc_n);
         a_iowc  += int'(!bus.iowc_n);
         a_aiowc += int'(!bus.aiowc_n);
         a_inta  += int'(!bus.inta_n);
         if (a_fst < 0 && !(bus.mrdc_n && bus.mwtc_n && bus.amwc_n && bus.iorc_n &&
                            bus.iowc_n && bus.aiowc_n && bus.inta_n)) a_fst = a_busy;
         if (a_fnw < 0 && !(bus.mwtc_n && bus.iowc_n)) a_fnw = a_busy;
         if (bus.busy) a_busy++;
         if (prev_busy && !bus.busy) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_cycle", 1, 0);
            end else begin
               prof_t e;
               e = sb_q.pop_front();
               chk({e.tag, "_busy"}, a_busy, e.busy);
               chk({e.tag, "_ale"}, a_ale, e.ale);
               chk({e.tag, "_den"}, a_den, e.den);
               chk({e.tag, "_dtr_lo"}, a_dtr, e.dtr_lo);
               chk({e.tag, "_mrdc"}, a_mrdc, e.mrdc);
               chk({e.tag, "_mwtc"}, a_mwtc, e.mwtc);
               chk({e.tag, "_amwc"}, a_amwc, e.amwc);
               chk({e.tag, "_iorc"}, a_iorc, e.iorc);
               chk({e.tag, "_iowc"}, a_iowc, e.iowc);
               chk({e.tag, "_aiowc"}, a_aiowc, e.aiowc);
               chk({e.tag, "_inta"}, a_inta, e.inta);
               chk({e.tag, "_first_cmd"}, a_fst, e.fst);
               chk({e.tag, "_first_wr"}, a_fnw, e.fnw);
            end
            n_done++;
            a_busy = 0; a_ale = 0; a_den = 0; a_dtr = 0; a_mrdc = 0; a_mwtc = 0;
            a_amwc = 0; a_iorc = 0; a_iowc = 0; a_aiowc = 0; a_inta = 0;
            a_fst = -1; a_fnw = -1;
         end
         prev_busy = bus.busy;
      end
   end

   task automatic idle_checks(input string tag);
      chk({tag, "_idle_busy"}, int'(bus.busy), 0);
      chk({tag, "_idle_den"}, int'(bus.den), 0);
      chk({tag, "_idle_dtr"}, int'(bus.dtr), 1);
      chk({tag, "_idle_cmds"}, int'({bus.mrdc_n, bus.mwtc_n, bus.amwc_n, bus.iorc_n,
                                     bus.iowc_n, bus.aiowc_n, bus.inta_n}), 7'h7f);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && n_done < n_push; i++) @(posedge clk);
      #1;
      chk({tag, "_done"}, n_done, n_push);
   endtask

   // One bus cycle: r = clocks of ready low after forced waits, mid = status after T1.
   task automatic run_txn(input string tag, input logic [2:0] code, input int r, input bit aen,
                          input logic [2:0] mid);
      int w;
      w = code[2] ? MemWaits : IoWaits;
      @(negedge clk);
      bus.s_n = code;
      bus.aen_n = aen;
      if (r > 0) bus.ready = 1'b0;
      sb_q.push_back(model(tag, code, r, aen));
      n_push++;
      @(posedge clk);
      #1;
      chk({tag, "_start_ale"}, int'(bus.ale), 1);
      bus.s_n = mid;
      if (r > 0) begin
         repeat (2 + w + r) @(posedge clk);
         #1 bus.ready = 1'b1;
      end
      wait_done(tag);
      bus.s_n = 3'b111;
      bus.aen_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle_checks(tag);
   endtask

   initial begin
      rst = 1'b0;
      bus.s_n = 3'b111;
      bus.ready = 1'b1;
      bus.aen_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ale", int'(bus.ale), 0);
      idle_checks("rst");
      rst = 1'b1;
      mon_en = 1'b1;

      run_txn("mrd", 3'b101, 0, 1'b0, 3'b111);
      run_txn("mwr", 3'b110, 0, 1'b0, 3'b111);
      run_txn("iord_mid", 3'b001, 0, 1'b0, 3'b110);
      run_txn("iord_rdy", 3'b001, 2, 1'b0, 3'b111);
      run_txn("halt", 3'b011, 0, 1'b0, 3'b111);
      run_txn("fetch", 3'b100, 0, 1'b0, 3'b111);
      run_txn("mrd_aen", 3'b101, 0, 1'b1, 3'b111);
      run_txn("inta", 3'b000, 0, 1'b0, 3'b111);
      run_txn("iowr_rdy", 3'b010, 1, 1'b0, 3'b111);
      run_txn("mwr_rdy", 3'b110, 3, 1'b0, 3'b111);

      // Reset asserted during T3 of a memory write.
      @(negedge clk);
      bus.s_n = 3'b110;
      sb_q.push_back('{tag: "mwr_rst", busy: 3, ale: 1, den: 2, dtr_lo: 0, mrdc: 0, mwtc: 1,
                       amwc: 2, iorc: 0, iowc: 0, aiowc: 0, inta: 0, fst: 1, fnw: 2});
      n_push++;
      @(posedge clk);
      #1 bus.s_n = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_t3_mwtc_active", int'(bus.mwtc_n), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_abort_mwtc", int'(bus.mwtc_n), 1);
      chk("rst_abort_amwc", int'(bus.amwc_n), 1);
      chk("rst_abort_den", int'(bus.den), 0);
      chk("rst_abort_dtr", int'(bus.dtr), 1);
      chk("rst_abort_busy", int'(bus.busy), 0);
      rst = 1'b1;
      wait_done("mwr_rst");
      repeat (2) @(posedge clk);

      run_txn("mrd_after_rst", 3'b101, 0, 1'b0, 3'b111);

      chk("sb_left", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
